// File: rtl/pito_boot_loader_pkg.sv
// Shared types for the pito boot loader: command bytes, FSM states and the
// command decoder used both from IDLE and from the last write of a packet.
package pito_boot_loader_pkg;

  localparam int LOADER_WORD_BYTES   = 4;
  localparam int LOADER_IMEM_AW_DEF  = 12;
  localparam int LOADER_DMEM_AW_DEF  = 12;

  typedef enum logic [7:0] {
    LDR_IMEM = 8'h01,
    LDR_DMEM = 8'h02,
    LDR_GO   = 8'h03,
    LDR_HALT = 8'h04
  } loader_cmd_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
    WR   = 3'd3,
    RUN  = 3'd4
  } loader_state_t;

  typedef enum logic {
    TGT_IMEM = 1'b0,
    TGT_DMEM = 1'b1
  } loader_tgt_t;

  typedef struct packed {
    loader_state_t state;
    loader_tgt_t   tgt;
    logic          bad;
  } cmd_dec_t;

  // HALT outside RUN is a legal no-op; anything unknown flags an error.
  function automatic cmd_dec_t decode_cmd(input logic [7:0] b, input loader_tgt_t tgt);
    cmd_dec_t r;
    r.state = IDLE;
    r.tgt   = tgt;
    r.bad   = 1'b0;
    case (b)
      LDR_IMEM: begin r.state = HDR; r.tgt = TGT_IMEM; end
      LDR_DMEM: begin r.state = HDR; r.tgt = TGT_DMEM; end
      LDR_GO:   r.state = RUN;
      LDR_HALT: r.state = IDLE;
      default:  r.bad = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pito_boot_loader_timeout.sv
// Inter-byte watchdog: reloads to CYCLES on every reload pulse and counts down
// to zero, where it raises expired until the next reload.
module pito_loader_timeout #(
  parameter int CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic reload,
  output logic expired
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (reload) begin
      cnt_d = CW'(CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CW'(CYCLES);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/pito_boot_loader.sv
// UART-fed boot loader: decodes load/GO/HALT packets, writes 32-bit words into
// imem/dmem through their external ports and holds the core in reset until GO.
module pito_boot_loader
  import pito_boot_loader_pkg::*;
#(
  parameter int IMEM_ADDR_WIDTH = LOADER_IMEM_AW_DEF,
  parameter int DMEM_ADDR_WIDTH = LOADER_DMEM_AW_DEF,
  parameter int TIMEOUT_CYCLES  = 1_000_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  output logic                       imem_req,
  output logic                       imem_we,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]                imem_wdata,
  output logic [3:0]                 imem_be,
  output logic                       dmem_req,
  output logic                       dmem_we,
  output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
  output logic [31:0]                dmem_wdata,
  output logic [3:0]                 dmem_be,
  output logic                       core_rst_n,
  output logic                       boot_done,
  output logic                       err
);

  localparam int BW = $clog2(LOADER_WORD_BYTES);

  loader_state_t state_q, state_d;
  loader_tgt_t   tgt_q, tgt_d;
  logic [1:0]    hdr_idx_q, hdr_idx_d;
  logic [BW-1:0] byte_idx_q, byte_idx_d;
  logic [15:0]   count_q, count_d;
  logic [15:0]   addr_q, addr_d;
  logic [31:0]   wbuf_q, wbuf_d;
  logic          err_q, err_d;

  logic                       imem_req_q, imem_req_d;
  logic [IMEM_ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]                imem_wdata_q, imem_wdata_d;
  logic [3:0]                 imem_be_q, imem_be_d;
  logic                       dmem_req_q, dmem_req_d;
  logic [DMEM_ADDR_WIDTH-1:0] dmem_addr_q, dmem_addr_d;
  logic [31:0]                dmem_wdata_q, dmem_wdata_d;
  logic [3:0]                 dmem_be_q, dmem_be_d;
  logic                       core_rst_n_q, core_rst_n_d;

  logic     to_reload, to_expired;
  cmd_dec_t dec;

  // The watchdog only runs while a packet is half received.
  assign to_reload = rx_valid || !((state_q == HDR) || (state_q == DATA));

  pito_loader_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .reload  (to_reload),
    .expired (to_expired)
  );

  assign dec = decode_cmd(rx_data, tgt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tgt_q        <= TGT_IMEM;
      hdr_idx_q    <= '0;
      byte_idx_q   <= '0;
      count_q      <= '0;
      addr_q       <= '0;
      wbuf_q       <= '0;
      err_q        <= 1'b0;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      imem_be_q    <= '0;
      dmem_req_q   <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      dmem_be_q    <= '0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      hdr_idx_q    <= hdr_idx_d;
      byte_idx_q   <= byte_idx_d;
      count_q      <= count_d;
      addr_q       <= addr_d;
      wbuf_q       <= wbuf_d;
      err_q        <= err_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      imem_be_q    <= imem_be_d;
      dmem_req_q   <= dmem_req_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_be_q    <= dmem_be_d;
      core_rst_n_q <= core_rst_n_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    hdr_idx_d  = hdr_idx_q;
    byte_idx_d = byte_idx_q;
    count_d    = count_q;
    addr_d     = addr_q;
    wbuf_d     = wbuf_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          state_d   = dec.state;
          tgt_d     = dec.tgt;
          hdr_idx_d = '0;
          if (dec.bad) err_d = 1'b1;
        end
      end
      HDR: begin
        if (rx_valid) begin
          hdr_idx_d = hdr_idx_q + 2'd1;
          case (hdr_idx_q)
            2'd0: count_d[7:0]  = rx_data;
            2'd1: count_d[15:8] = rx_data;
            2'd2: addr_d[7:0]   = rx_data;
            default: begin
              addr_d[15:8] = rx_data;
              byte_idx_d   = '0;
              state_d      = (count_q == 16'd0) ? IDLE : DATA;
            end
          endcase
        end else if (to_expired) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      DATA: begin
        if (rx_valid) begin
          wbuf_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
          byte_idx_d = byte_idx_q + BW'(1);
          if (byte_idx_q == BW'(LOADER_WORD_BYTES - 1)) state_d = WR;
        end else if (to_expired) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      WR: begin
        addr_d  = addr_q + 16'd1;
        count_d = count_q - 16'd1;
        // A byte landing here belongs to the next word, or to the next packet.
        if (count_q == 16'd1) begin
          state_d = IDLE;
          if (rx_valid) begin
            state_d   = dec.state;
            tgt_d     = dec.tgt;
            hdr_idx_d = '0;
            if (dec.bad) err_d = 1'b1;
          end
        end else begin
          state_d = DATA;
          if (rx_valid) begin
            wbuf_d[7:0] = rx_data;
            byte_idx_d  = BW'(1);
          end
        end
      end
      RUN: begin
        if (rx_valid && (rx_data == LDR_HALT)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so the strobe lands one cycle
  // after the last data byte.
  always_comb begin
    imem_req_d   = (state_d == WR) && (tgt_d == TGT_IMEM);
    dmem_req_d   = (state_d == WR) && (tgt_d == TGT_DMEM);
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    imem_be_d    = 4'h0;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_be_d    = 4'h0;
    if (imem_req_d) begin
      imem_addr_d  = addr_q[IMEM_ADDR_WIDTH-1:0];
      imem_wdata_d = wbuf_d;
      imem_be_d    = 4'hF;
    end
    if (dmem_req_d) begin
      dmem_addr_d  = addr_q[DMEM_ADDR_WIDTH-1:0];
      dmem_wdata_d = wbuf_d;
      dmem_be_d    = 4'hF;
    end
    core_rst_n_d = (state_d == RUN);
  end

  assign imem_req   = imem_req_q;
  assign imem_we    = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign imem_be    = imem_be_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_req_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign dmem_be    = dmem_be_q;
  assign core_rst_n = core_rst_n_q;
  assign boot_done  = core_rst_n_q;
  assign err        = err_q;

endmodule

// File: tb/tb_pito_boot_loader.sv
// Directed bench for pito_boot_loader: expected memory writes go into a
// scoreboard queue and a negedge monitor checks every strobe against it.
module tb_pito_boot_loader;

  localparam int IW = 8;
  localparam int DW = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          imem_req, imem_we, dmem_req, dmem_we;
  logic [IW-1:0] imem_addr;
  logic [DW-1:0] dmem_addr;
  logic [31:0]   imem_wdata, dmem_wdata;
  logic [3:0]    imem_be, dmem_be;
  logic          core_rst_n, boot_done, err;

  typedef struct {
    bit          dm;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pito_boot_loader #(
    .IMEM_ADDR_WIDTH (IW),
    .DMEM_ADDR_WIDTH (DW),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .imem_req   (imem_req),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .imem_be    (imem_be),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_be    (dmem_be),
    .core_rst_n (core_rst_n),
    .boot_done  (boot_done),
    .err        (err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input bit dm, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.dm = dm;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic chk_all_reset(input string tag);
    chk({tag, "_req"}, {30'b0, imem_req, dmem_req}, 32'd0);
    chk({tag, "_we"}, {30'b0, imem_we, dmem_we}, 32'd0);
    chk({tag, "_addr"}, {16'b0, 8'(imem_addr), 8'(dmem_addr)}, 32'd0);
    chk({tag, "_wdata"}, imem_wdata | dmem_wdata, 32'd0);
    chk({tag, "_be"}, {24'b0, imem_be, dmem_be}, 32'd0);
    chk({tag, "_core"}, {29'b0, core_rst_n, boot_done, err}, 32'd0);
  endtask

  // Monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_req || dmem_req) begin
      chk("one_port_active", {31'b0, imem_req & dmem_req}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write imem_req=%0b dmem_req=%0b addr=%0h/%0h", imem_req, dmem_req, imem_addr, dmem_addr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_port_dmem", {31'b0, dmem_req}, {31'b0, e.dm});
        chk("wr_addr", dmem_req ? 32'(dmem_addr) : 32'(imem_addr), e.addr);
        chk("wr_data", dmem_req ? dmem_wdata : imem_wdata, e.data);
        chk("wr_be", {28'b0, dmem_req ? dmem_be : imem_be}, 32'hF);
        chk("wr_we", {31'b0, dmem_req ? dmem_we : imem_we}, 32'd1);
      end
    end
  end

  initial begin
    int guard;
    #1;
    chk_all_reset("reset_hold");
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all_reset("reset_release");

    // Imem load of two words at 0x10.
    push(1'b0, 32'h10, 32'hDEADBEEF);
    push(1'b0, 32'h11, 32'h12345678);
    send(8'h01); idle(1); send(8'h02); idle(1); send(8'h00); idle(1);
    send(8'h10); idle(1); send(8'h00); idle(1);
    send(8'hEF); idle(1); send(8'hBE); idle(1); send(8'hAD); idle(1);
    chk("imem_no_early_strobe", {31'b0, imem_req}, 32'd0);
    send(8'hDE);
    chk("imem_strobe_timing", {31'b0, imem_req}, 32'd1);
    idle(1);
    chk("imem_strobe_one_cycle", {31'b0, imem_req}, 32'd0);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    idle(2);
    chk("imem_load_core_held", {31'b0, core_rst_n}, 32'd0);

    // Dmem load, ADDR 0x00FF truncates to 0xF and wraps to 0.
    push(1'b1, 32'hF, 32'hA1A2A3A4);
    push(1'b1, 32'h0, 32'h0B0C0D0E);
    send(8'h02); idle(1); send(8'h02); send(8'h00); send(8'hFF); send(8'h00);
    send(8'hA4); send(8'hA3); send(8'hA2); send(8'hA1); idle(1);
    send(8'h0E); send(8'h0D); send(8'h0C); send(8'h0B);
    idle(2);
    chk("dmem_wrap_err", {31'b0, err}, 32'd0);

    // Zero-count packet, then GO and HALT.
    send(8'h02); send(8'h00); send(8'h00); send(8'h00); send(8'h00);
    idle(2);
    chk("go_before", {30'b0, core_rst_n, boot_done}, 32'd0);
    send(8'h03);
    chk("go_after", {30'b0, core_rst_n, boot_done}, 32'd3);
    send(8'h55); idle(1);
    chk("run_ignores_bytes", {30'b0, core_rst_n, boot_done}, 32'd3);
    send(8'h04);
    chk("halt_after", {30'b0, core_rst_n, boot_done}, 32'd0);

    // Timeout mid-packet, then a clean packet.
    send(8'h01); send(8'h01); send(8'h00); send(8'h20); send(8'h00);
    send(8'h99); send(8'h98);
    idle(TO - 4);
    chk("timeout_not_yet", {31'b0, err}, 32'd0);
    idle(10);
    chk("timeout_err", {31'b0, err}, 32'd1);
    push(1'b0, 32'h30, 32'h44332211);
    send(8'h01); send(8'h01); send(8'h00); send(8'h30); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    idle(2);

    // Async reset during DATA clears outputs and err with no partial write.
    send(8'h01); send(8'h01); send(8'h00); send(8'h50); send(8'h00);
    send(8'hEF); send(8'hBE);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_reset("async_reset");
    @(posedge clk);
    #1;
    send(8'hAD); send(8'hDE);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(3);
    chk_all_reset("after_reset");

    // Back-to-back packet; byte 05 lands during WR, then GO lands during WR.
    push(1'b0, 32'h40, 32'h04030201);
    push(1'b0, 32'h41, 32'h08070605);
    send(8'h01); send(8'h02); send(8'h00); send(8'h40); send(8'h00);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h05); send(8'h06); send(8'h07); send(8'h08);
    send(8'h03);
    chk("b2b_go_in_wr", {30'b0, core_rst_n, boot_done}, 32'd3);
    send(8'h04);
    chk("b2b_halt", {31'b0, core_rst_n}, 32'd0);
    chk("bad_cmd_before", {31'b0, err}, 32'd0);
    send(8'h7F);
    chk("bad_cmd_err", {31'b0, err}, 32'd1);
    idle(3);
    chk("err_sticky", {31'b0, err}, 32'd1);

    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      idle(1);
      guard++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
